pmod_cls_text_sequencer: RTL

- Upstream command sequencer for the PMOD CLS custom driver; converts a single "display these two lines" request into the driver's clear / write-line-1 / write-line-2 command handshake.
- Latches the requested text on request, stalls on the driver's command-ready, and holds each command until the driver accepts it.
- Also performs a periodic refresh so the display recovers from glitches.
- Sits between the application text formatter and the CLS driver, in the 20 MHz domain, paced by the 2.5 MHz clock enable.

---
 rtl/pmod_cls_text_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pmod_cls_text_sequencer.sv
// PMOD CLS text sequencer: turns a two-line display request into
// the driver's clear / line1 / line2 command handshake, with refresh.
module pmod_cls_text_sequencer #(
  parameter int parm_fast_simulation = 0,
  parameter int FCLK_ce              = 2500000,
  parameter int parm_refresh_ms      = 1000,
  parameter int parm_clear_on_update = 1,
  parameter int parm_ack_timeout     = 255
) (
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic         i_ce_2_5mhz,
  input  logic         i_update,
  input  logic [127:0] i_line1,
  input  logic [127:0] i_line2,
  output logic         o_busy,
  output logic         o_seq_done,
  output logic         o_seq_error,
  input  logic         i_command_ready,
  output logic         o_cmd_wr_clear_display,
  output logic         o_cmd_wr_text_line1,
  output logic         o_cmd_wr_text_line2,
  output logic [127:0] o_dat_ascii_line1,
  output logic [127:0] o_dat_ascii_line2
);

  localparam logic [127:0] SPACES = {16{8'h20}};

  localparam bit REF_EN   = (parm_refresh_ms != 0);
  localparam bit CLEAR_EN = (parm_clear_on_update != 0);

  localparam int unsigned REF_TC =
    !REF_EN                     ? 1 :
    (parm_fast_simulation != 0) ? parm_refresh_ms - 1 :
    parm_refresh_ms * (FCLK_ce / 1000) - 1;
  localparam int RW = (REF_TC < 1) ? 1 : $clog2(REF_TC + 1);
  localparam logic [RW-1:0] REF_TC_W = RW'(REF_TC);

  localparam int unsigned ACK_LAST =
    (parm_ack_timeout > 0) ? parm_ack_timeout - 1 : 0;
  localparam int AW = (parm_ack_timeout < 2) ? 1
                      : $clog2(parm_ack_timeout + 1);
  localparam logic [AW-1:0] ACK_LAST_W = AW'(ACK_LAST);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLR_WAIT,
    ST_CLR_ISSUE,
    ST_L1_WAIT,
    ST_L1_ISSUE,
    ST_L2_WAIT,
    ST_L2_ISSUE,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          pend_q;
  logic [127:0]  sh1_q, sh2_q;
  logic [127:0]  dat1_q, dat2_q;
  logic [AW-1:0] ack_q;
  logic [RW-1:0] ref_cnt_q;
  logic          ref_exp_q;

  logic rdy;
  logic ref_hit;
  logic ack_last;
  logic is_issue;
  logic consume;
  logic to_done;
  logic busy;

  assign rdy      = i_command_ready;
  assign ref_hit  = REF_EN && (ref_exp_q || (ref_cnt_q == REF_TC_W));
  assign ack_last = (ack_q == ACK_LAST_W);
  assign is_issue = (state_q == ST_CLR_ISSUE) ||
                    (state_q == ST_L1_ISSUE)  ||
                    (state_q == ST_L2_ISSUE);
  assign consume  = i_ce_2_5mhz && (state_q == ST_IDLE) &&
                    (state_d == ST_LOAD);
  assign to_done  = i_ce_2_5mhz && (state_q != ST_DONE) &&
                    (state_d == ST_DONE);

  // Next-state and decoded outputs; commands follow the ISSUE states.
  always_comb begin
    state_d                = state_q;
    busy                   = 1'b0;
    o_seq_done             = 1'b0;
    o_seq_error            = 1'b0;
    o_cmd_wr_clear_display = 1'b0;
    o_cmd_wr_text_line1    = 1'b0;
    o_cmd_wr_text_line2    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_ce_2_5mhz && (pend_q || ref_hit)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (i_ce_2_5mhz)
          state_d = CLEAR_EN ? ST_CLR_WAIT : ST_L1_WAIT;
      end
      ST_CLR_WAIT: begin
        busy = 1'b1;
        if (i_ce_2_5mhz && rdy) state_d = ST_CLR_ISSUE;
      end
      ST_CLR_ISSUE: begin
        busy = 1'b1;
        o_cmd_wr_clear_display = 1'b1;
        if (i_ce_2_5mhz) begin
          if (!rdy)          state_d = ST_L1_WAIT;
          else if (ack_last) state_d = ST_ERR;
        end
      end
      ST_L1_WAIT: begin
        busy = 1'b1;
        if (i_ce_2_5mhz && rdy) state_d = ST_L1_ISSUE;
      end
      ST_L1_ISSUE: begin
        busy = 1'b1;
        o_cmd_wr_text_line1 = 1'b1;
        if (i_ce_2_5mhz) begin
          if (!rdy)          state_d = ST_L2_WAIT;
          else if (ack_last) state_d = ST_ERR;
        end
      end
      ST_L2_WAIT: begin
        busy = 1'b1;
        if (i_ce_2_5mhz && rdy) state_d = ST_L2_ISSUE;
      end
      ST_L2_ISSUE: begin
        busy = 1'b1;
        o_cmd_wr_text_line2 = 1'b1;
        if (i_ce_2_5mhz) begin
          if (!rdy)          state_d = ST_DONE;
          else if (ack_last) state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        o_seq_done = 1'b1;
        if (i_ce_2_5mhz) state_d = ST_IDLE;
      end
      ST_ERR: begin
        o_seq_error = 1'b1;
        if (i_ce_2_5mhz) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy            = busy;
  assign o_dat_ascii_line1 = dat1_q;
  assign o_dat_ascii_line2 = dat2_q;

  // State register and per-command ack counter.
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
    end else if (i_ce_2_5mhz) begin
      state_q <= state_d;
      if (state_d != state_q) ack_q <= '0;
      else if (is_issue)      ack_q <= ack_q + 1'b1;
    end
  end

  // Request capture runs every clock; last request wins.
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      pend_q <= 1'b0;
      sh1_q  <= SPACES;
      sh2_q  <= SPACES;
    end else begin
      if (i_update) begin
        pend_q <= 1'b1;
        sh1_q  <= i_line1;
        sh2_q  <= i_line2;
      end else if (consume) begin
        pend_q <= 1'b0;
      end else if (i_ce_2_5mhz && state_q == ST_ERR) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Text presented to the driver changes only when a sequence loads.
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      dat1_q <= SPACES;
      dat2_q <= SPACES;
    end else if (consume) begin
      dat1_q <= sh1_q;
      dat2_q <= sh2_q;
    end
  end

  // Refresh timer: idles during a sequence, restarts on completion.
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      ref_cnt_q <= '0;
      ref_exp_q <= 1'b0;
    end else if (i_ce_2_5mhz) begin
      if (consume || to_done) begin
        ref_cnt_q <= '0;
        ref_exp_q <= 1'b0;
      end else if (!busy && REF_EN) begin
        if (ref_cnt_q == REF_TC_W) ref_exp_q <= 1'b1;
        else                       ref_cnt_q <= ref_cnt_q + 1'b1;
      end
    end
  end

endmodule
